// File: rtl/sequencer_pkg.sv
// Shared types and constants for the program sequencer and its watchdog.
package sequencer_pkg;

  // Default instruction width; the opcode field is the top nibble.
  localparam int OPW_DEFAULT = 20;
  localparam int OP_FIELD_W  = 4;

  // Opcode field values the sequencer itself interprets.
  localparam logic [OP_FIELD_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OP_FIELD_W-1:0] OP_HALT = 4'b1111;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_t;

  // True for every state in which an instruction is in flight.
  function automatic logic state_is_busy(input seq_state_t st);
    logic busy_v;
    case (st)
      ST_FETCH, ST_LOAD, ST_ISSUE, ST_WAIT: busy_v = 1'b1;
      default:                              busy_v = 1'b0;
    endcase
    return busy_v;
  endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// ROM fetch path and executor handshake between the sequencer and its peers.
interface program_sequencer_if #(
  parameter int PW  = 4,
  parameter int OPW = 20
);
  logic [PW-1:0]  ProgAddr;
  logic [OPW-1:0] ProgData;
  logic [OPW-1:0] OpCode;
  logic           ExecDone;
  logic           ResetN;

  // Sequencer side: drives address, opcode and the executor reset.
  modport master (
    output ProgAddr,
    output OpCode,
    output ResetN,
    input  ProgData,
    input  ExecDone
  );

  // ROM / executor side.
  modport slave (
    input  ProgAddr,
    input  OpCode,
    input  ResetN,
    output ProgData,
    output ExecDone
  );
endinterface

// File: rtl/seq_watchdog.sv
// Clear/enable cycle counter that flags when the next enabled cycle is the
// TIMEOUT-th one, so the caller can act on the edge that completes it.
module seq_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  input  logic enable,
  output logic at_limit
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_r;

  // Count enabled cycles; clear wins over enable; never wrap past 255.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_r <= 8'd0;
    end else if (clear) begin
      count_r <= 8'd0;
    end else if (enable && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Kept independent of enable so the caller's decode has no comb loop.
  assign at_limit = (count_r >= LIMIT);

endmodule

// File: rtl/program_sequencer.sv
// Fetches instructions from a synchronous ROM and hands them one at a time to
// the executor, with start/stop control, HALT and end-of-program detection
// and a stuck-executor watchdog.
module program_sequencer
  import sequencer_pkg::*;
#(
  parameter int PW      = 4,
  parameter int OPW     = OPW_DEFAULT,
  parameter int TIMEOUT = 15
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Start,
  input  logic                Stop,
  program_sequencer_if.master bus,
  output logic                Busy,
  output logic                Halted,
  output logic                Error,
  output logic [7:0]          RetireCount
);

  localparam logic [PW-1:0]  PC_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0]  PC_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]  PC_LAST  = {PW{1'b1}};
  localparam logic [OPW-1:0] NOP_WORD = {OP_NOP, {(OPW-OP_FIELD_W){1'b0}}};

  seq_state_t     state_r, state_s;
  logic [PW-1:0]  pc_r, pc_s;
  logic [OPW-1:0] ir_r, ir_s;
  logic           stop_pending_r, stop_pending_s;
  logic           error_r, error_s;
  logic [7:0]     retire_r, retire_s;
  logic           busy_r, halted_r;
  logic           wd_clear_s, wd_enable_s, wd_at_limit_s;
  logic [OPW-1:0] opcode_s;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .Clock    (Clock),
    .Reset    (Reset),
    .clear    (wd_clear_s),
    .enable   (wd_enable_s),
    .at_limit (wd_at_limit_s)
  );

  // Next-state, PC, IR, retire counter and sticky error decode.
  always_comb begin
    state_s        = state_r;
    pc_s           = pc_r;
    ir_s           = ir_r;
    stop_pending_s = stop_pending_r;
    error_s        = error_r;
    retire_s       = retire_r;
    wd_clear_s     = 1'b0;
    wd_enable_s    = 1'b0;

    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (Start) begin
          state_s        = ST_FETCH;
          pc_s           = PC_ZERO;
          retire_s       = 8'd0;
          error_s        = 1'b0;
          stop_pending_s = 1'b0;
          wd_clear_s     = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_FETCH: begin
        state_s = ST_LOAD;
      end
      ST_LOAD: begin
        // ROM data is valid now; a HALT word is captured but never issued.
        ir_s = bus.ProgData;
        if (bus.ProgData[OPW-1 -: OP_FIELD_W] == OP_HALT) begin
          state_s = ST_HALTED;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wd_clear_s = 1'b1;
        state_s    = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ExecDone) begin
          if (retire_r != 8'hFF) begin
            retire_s = retire_r + 8'd1;
          end else begin
            retire_s = retire_r;
          end
          if (stop_pending_r) begin
            state_s = ST_IDLE;
          end else if (pc_r == PC_LAST) begin
            state_s = ST_HALTED;
          end else begin
            pc_s    = pc_r + PC_ONE;
            state_s = ST_FETCH;
          end
        end else begin
          wd_enable_s = 1'b1;
          if (wd_at_limit_s) begin
            error_s = 1'b1;
            state_s = ST_HALTED;
          end else begin
            state_s = ST_WAIT;
          end
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // A stop request is only remembered while work is in flight.
    if (state_is_busy(state_r) && Stop) begin
      stop_pending_s = 1'b1;
    end else begin
      stop_pending_s = stop_pending_s;
    end
  end

  // State and datapath registers; status flags registered from next state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r        <= ST_IDLE;
      pc_r           <= PC_ZERO;
      ir_r           <= NOP_WORD;
      stop_pending_r <= 1'b0;
      error_r        <= 1'b0;
      retire_r       <= 8'd0;
      busy_r         <= 1'b0;
      halted_r       <= 1'b0;
    end else begin
      state_r        <= state_s;
      pc_r           <= pc_s;
      ir_r           <= ir_s;
      stop_pending_r <= stop_pending_s;
      error_r        <= error_s;
      retire_r       <= retire_s;
      busy_r         <= state_is_busy(state_s);
      halted_r       <= (state_s == ST_HALTED);
    end
  end

  // Opcode must fall to NOP in the very cycle Done is seen, otherwise the
  // executor restarts the held instruction on the next edge.
  always_comb begin
    opcode_s = NOP_WORD;
    if (Reset) begin
      opcode_s = NOP_WORD;
    end else if (state_r == ST_ISSUE) begin
      opcode_s = ir_r;
    end else if ((state_r == ST_WAIT) && !bus.ExecDone) begin
      opcode_s = ir_r;
    end else begin
      opcode_s = NOP_WORD;
    end
  end

  assign bus.OpCode   = opcode_s;
  assign bus.ProgAddr = pc_r;
  assign bus.ResetN   = ~Reset;

  assign Busy        = busy_r;
  assign Halted      = halted_r;
  assign Error       = error_r;
  assign RetireCount = retire_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench: ROM and executor models, issue scoreboard, one task
// per scenario.
`timescale 1ns/1ps
module tb_program_sequencer;
  import sequencer_pkg::*;

  localparam int PW      = 4;
  localparam int OPW     = 20;
  localparam int TIMEOUT = 15;
  localparam logic [OPW-1:0] HALT_W = 20'hF0000;

  logic       Clock = 1'b0;
  logic       Reset, Start, Stop;
  logic       Busy, Halted, Error;
  logic [7:0] RetireCount;

  int checks = 0;
  int errors = 0;

  program_sequencer_if #(.PW(PW), .OPW(OPW)) bus ();

  program_sequencer #(.PW(PW), .OPW(OPW), .TIMEOUT(TIMEOUT)) dut (
    .Clock       (Clock),
    .Reset       (Reset),
    .Start       (Start),
    .Stop        (Stop),
    .bus         (bus),
    .Busy        (Busy),
    .Halted      (Halted),
    .Error       (Error),
    .RetireCount (RetireCount)
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM model
  logic [OPW-1:0] rom [16];
  always @(posedge Clock) bus.ProgData <= rom[bus.ProgAddr];

  // Executor model: registered Done after k steps; a held opcode restarts.
  logic done_r = 1'b0;
  logic hang = 1'b0;
  int   cnt = 0;
  int   exec_starts = 0;
  function automatic int steps_for(input logic [3:0] op);
    case (op)
      4'h1:    return 2;  // LOAD_CONST
      4'h3:    return 4;  // SUB_REG
      default: return 1;  // undefined: immediate done
    endcase
  endfunction
  always @(posedge Clock) begin
    if (!bus.ResetN) begin
      done_r <= 1'b0;
      cnt    <= 0;
    end else if (cnt > 0) begin
      cnt    <= cnt - 1;
      done_r <= (cnt == 1);
    end else if (bus.OpCode != 20'h00000) begin
      exec_starts <= exec_starts + 1;
      if (steps_for(bus.OpCode[19:16]) == 1) begin
        done_r <= 1'b1;
      end else begin
        done_r <= 1'b0;
        cnt    <= steps_for(bus.OpCode[19:16]) - 1;
      end
    end else begin
      done_r <= 1'b0;
    end
  end
  assign bus.ExecDone = hang ? 1'b0 : done_r;

  // Issue scoreboard: expected opcodes queued by the tests, popped on issue.
  logic [OPW-1:0] exp_q [$];
  logic [OPW-1:0] prev_op = 20'h00000;
  logic [OPW-1:0] exp_op;
  always @(negedge Clock) begin
    if (bus.OpCode != 20'h00000 && prev_op == 20'h00000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected got=%h expected none", bus.OpCode);
      end else begin
        exp_op = exp_q.pop_front();
        if (bus.OpCode !== exp_op) begin
          errors++;
          $display("FAIL issue_opcode got=%h expected=%h", bus.OpCode, exp_op);
        end
      end
    end
    prev_op <= bus.OpCode;
  end

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic do_reset();
    Reset = 1'b1; Start = 1'b0; Stop = 1'b0; hang = 1'b0;
    tick(); tick();
    Reset = 1'b0;
    exp_q.delete();
    exec_starts = 0;
  endtask

  task automatic fill_rom(input logic [OPW-1:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  task automatic pulse_start();
    Start = 1'b1; tick(); Start = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b expected=0", Busy); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL rst_halted got=%b expected=0", Halted); end
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL rst_error got=%b expected=0", Error); end
    checks++; if (RetireCount !== 8'd0) begin errors++; $display("FAIL rst_retire got=%0d expected=0", RetireCount); end
    checks++; if (bus.OpCode !== 20'h00000) begin errors++; $display("FAIL rst_opcode got=%h expected=0", bus.OpCode); end
    checks++; if (bus.ProgAddr !== 4'd0) begin errors++; $display("FAIL rst_addr got=%0d expected=0", bus.ProgAddr); end
  endtask

  // LOAD_CONST then HALT: opcode visible in ISSUE and the Done=0 WAIT cycle.
  task automatic test_load_const_halt();
    logic [OPW-1:0] want;
    do_reset();
    fill_rom(HALT_W);
    rom[0] = 20'h10105;
    exp_q.push_back(20'h10105);
    Start = 1'b1;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      tick();
      if (cyc == 1) Start = 1'b0;
      want = (cyc == 3 || cyc == 4) ? 20'h10105 : 20'h00000;
      checks++;
      if (bus.OpCode !== want) begin errors++; $display("FAIL lc_opcode cyc=%0d got=%h expected=%h", cyc, bus.OpCode, want); end
      if (cyc == 7) begin
        checks++; if (Halted !== 1'b0 || Busy !== 1'b1) begin errors++; $display("FAIL lc_early_halt halted=%b busy=%b expected 0/1", Halted, Busy); end
      end
      if (cyc == 8) begin
        checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL lc_halted got=%b expected=1", Halted); end
        checks++; if (RetireCount !== 8'd1) begin errors++; $display("FAIL lc_retire got=%0d expected=1", RetireCount); end
      end
    end
    checks++; if (exec_starts !== 1) begin errors++; $display("FAIL lc_exec_starts got=%0d expected=1", exec_starts); end
  endtask

  // Two undefined opcodes back to back, 4 cycles each, then HALT.
  task automatic test_back_to_back();
    do_reset();
    fill_rom(HALT_W);
    rom[0] = 20'h2AA55;
    rom[1] = 20'h5C3C3;
    exp_q.push_back(20'h2AA55);
    exp_q.push_back(20'h5C3C3);
    Start = 1'b1;
    for (int cyc = 1; cyc <= 11; cyc++) begin
      tick();
      if (cyc == 1) Start = 1'b0;
      if (cyc == 10) begin
        checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL b2b_early_halt got=%b expected=0", Halted); end
      end
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL b2b_halted got=%b expected=1", Halted); end
    checks++; if (RetireCount !== 8'd2) begin errors++; $display("FAIL b2b_retire got=%0d expected=2", RetireCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_pending got=%0d expected=0", exp_q.size()); end
  endtask

  // 16 words, no HALT: stops at the last address without wrapping.
  task automatic test_end_of_program();
    logic wrapped = 1'b0;
    logic [PW-1:0] last_addr;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      rom[i] = {4'h1, 8'(i), 8'h00};
      exp_q.push_back({4'h1, 8'(i), 8'h00});
    end
    pulse_start();
    last_addr = bus.ProgAddr;
    for (int i = 0; i < 200 && !Halted; i++) begin
      tick();
      if (last_addr == 4'd15 && bus.ProgAddr == 4'd0) wrapped = 1'b1;
      last_addr = bus.ProgAddr;
    end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL eop_halted got=%b expected=1", Halted); end
    checks++; if (RetireCount !== 8'd16) begin errors++; $display("FAIL eop_retire got=%0d expected=16", RetireCount); end
    checks++; if (bus.ProgAddr !== 4'd15) begin errors++; $display("FAIL eop_addr got=%0d expected=15", bus.ProgAddr); end
    checks++; if (wrapped !== 1'b0) begin errors++; $display("FAIL eop_wrap got=%b expected=0", wrapped); end
    checks++; if (exec_starts !== 16) begin errors++; $display("FAIL eop_exec_starts got=%0d expected=16", exec_starts); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL eop_pending got=%0d expected=0", exp_q.size()); end
  endtask

  // Stop raised during WAIT of word 2: word 2 retires, then IDLE.
  task automatic test_stop();
    logic found = 1'b0;
    do_reset();
    fill_rom(HALT_W);
    for (int i = 0; i < 6; i++) rom[i] = {4'h1, 8'(i + 16), 8'h07};
    for (int i = 0; i < 3; i++) exp_q.push_back({4'h1, 8'(i + 16), 8'h07});
    pulse_start();
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (bus.ProgAddr == 4'd2 && bus.OpCode != 20'h00000) found = 1'b1;
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL stop_reach_w2 got=%b expected=1", found); end
    tick();  // first WAIT cycle of word 2
    Stop = 1'b1; tick(); Stop = 1'b0;
    for (int i = 0; i < 50 && Busy; i++) tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL stop_busy got=%b expected=0", Busy); end
    checks++; if (Halted !== 1'b0) begin errors++; $display("FAIL stop_halted got=%b expected=0", Halted); end
    checks++; if (RetireCount !== 8'd3) begin errors++; $display("FAIL stop_retire got=%0d expected=3", RetireCount); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_pending got=%0d expected=0", exp_q.size()); end
  endtask

  // Executor never finishes: watchdog halts with Error after 15 WAIT cycles.
  task automatic test_watchdog();
    do_reset();
    fill_rom(HALT_W);
    rom[0] = 20'h10105;
    exp_q.push_back(20'h10105);
    hang = 1'b1;
    Start = 1'b1;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      tick();
      if (cyc == 1) Start = 1'b0;
      if (cyc == 18) begin
        checks++; if (Error !== 1'b0 || Halted !== 1'b0) begin errors++; $display("FAIL wd_early error=%b halted=%b expected 0/0", Error, Halted); end
        checks++; if (bus.OpCode !== 20'h10105) begin errors++; $display("FAIL wd_held_op got=%h expected=10105", bus.OpCode); end
      end
    end
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL wd_error got=%b expected=1", Error); end
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL wd_halted got=%b expected=1", Halted); end
    checks++; if (bus.OpCode !== 20'h00000) begin errors++; $display("FAIL wd_opcode got=%h expected=0", bus.OpCode); end
    checks++; if (RetireCount !== 8'd0) begin errors++; $display("FAIL wd_retire got=%0d expected=0", RetireCount); end
    hang = 1'b0;
    rom[0] = HALT_W;
    tick(); tick(); tick(); tick(); tick(); tick();
    checks++; if (Error !== 1'b1) begin errors++; $display("FAIL wd_sticky got=%b expected=1", Error); end
    pulse_start();
    checks++; if (Error !== 1'b0) begin errors++; $display("FAIL wd_start_clear got=%b expected=0", Error); end
  endtask

  // Reset during WAIT of a SUB_REG returns everything to reset values.
  task automatic test_reset_mid();
    logic found = 1'b0;
    do_reset();
    fill_rom(HALT_W);
    rom[0] = 20'h31200;
    exp_q.push_back(20'h31200);
    pulse_start();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (bus.OpCode != 20'h00000) found = 1'b1;
    end
    tick(); tick();  // second WAIT cycle
    checks++; if (bus.OpCode !== 20'h31200) begin errors++; $display("FAIL rm_in_wait got=%h expected=31200", bus.OpCode); end
    Reset = 1'b1; tick();
    checks++; if (bus.OpCode !== 20'h00000) begin errors++; $display("FAIL rm_opcode got=%h expected=0", bus.OpCode); end
    checks++; if (Busy !== 1'b0 || Halted !== 1'b0 || Error !== 1'b0) begin errors++; $display("FAIL rm_flags busy=%b halted=%b error=%b expected 0/0/0", Busy, Halted, Error); end
    checks++; if (bus.ProgAddr !== 4'd0 || RetireCount !== 8'd0) begin errors++; $display("FAIL rm_counters addr=%0d retire=%0d expected 0/0", bus.ProgAddr, RetireCount); end
    checks++; if (bus.ExecDone !== 1'b0) begin errors++; $display("FAIL rm_exec_done got=%b expected=0", bus.ExecDone); end
    Reset = 1'b0;
    tick();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rm_stays_idle got=%b expected=0", Busy); end
    exp_q.delete();
  endtask

  // Start pulsed while busy must not restart the program.
  task automatic test_start_ignored();
    logic found = 1'b0;
    do_reset();
    fill_rom(HALT_W);
    for (int i = 0; i < 4; i++) begin
      rom[i] = {4'h1, 8'(i + 32), 8'h01};
      exp_q.push_back({4'h1, 8'(i + 32), 8'h01});
    end
    pulse_start();
    for (int i = 0; i < 50 && !found; i++) begin
      tick();
      if (bus.ProgAddr == 4'd1 && bus.OpCode != 20'h00000) found = 1'b1;
    end
    tick();
    Start = 1'b1; tick(); Start = 1'b0;
    checks++; if (bus.ProgAddr !== 4'd1 || Busy !== 1'b1) begin errors++; $display("FAIL si_pc addr=%0d busy=%b expected 1/1", bus.ProgAddr, Busy); end
    for (int i = 0; i < 100 && !Halted; i++) tick();
    checks++; if (Halted !== 1'b1) begin errors++; $display("FAIL si_halted got=%b expected=1", Halted); end
    checks++; if (RetireCount !== 8'd4) begin errors++; $display("FAIL si_retire got=%0d expected=4", RetireCount); end
    checks++; if (exec_starts !== 4) begin errors++; $display("FAIL si_exec_starts got=%0d expected=4", exec_starts); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL si_pending got=%0d expected=0", exp_q.size()); end
  endtask

  initial begin
    fill_rom(HALT_W);
    test_reset();
    test_load_const_halt();
    test_back_to_back();
    test_end_of_program();
    test_stop();
    test_watchdog();
    test_reset_mid();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
